axis_output_pipe: RTL and testbench

- Output-side counterpart of the conv-engine input pipe. Accepts one wide beat per accepted conv-engine output: COPIES×CORES×UNITS words, plus tlast and tuser.
- Serializes each beat into narrow AXI-Stream beats of M_DATA_WORDS words for the output DMA.
- Drops config beats and preserves frame tlast.
- Sits between the conv engine output and the M_AXIS output port of the accelerator.

---
 rtl/axis_output_pipe.sv | 104 ++++++++++
 tb/tb_axis_output_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_output_pipe.sv
// axis_output_pipe
// Output-side serializer for the conv engine. Each accepted wide beat of
// COPIES*CORES*UNITS words is held and emitted as SUB_BEATS narrow AXI-Stream
// beats of M_DATA_WORDS words, lowest-index words first. Config beats are
// accepted and dropped. Frame tlast is carried onto the final narrow beat.
module axis_output_pipe #(
  parameter int WORD_WIDTH   = 8,
  parameter int UNITS        = 4,
  parameter int CORES        = 2,
  parameter int COPIES       = 2,
  parameter int M_DATA_WORDS = 4,
  parameter int TUSER_WIDTH  = 4,
  parameter int I_IS_CONFIG  = 0
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,

  output logic                                      s_axis_tready,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  input  logic [WORD_WIDTH*COPIES*CORES*UNITS-1:0]  s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]                    s_axis_tuser,

  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  output logic [WORD_WIDTH*M_DATA_WORDS-1:0]        m_axis_tdata,
  output logic [WORD_WIDTH*M_DATA_WORDS/8-1:0]      m_axis_tkeep
);

  localparam int IN_WORDS  = COPIES * CORES * UNITS;
  localparam int SUB_BEATS = IN_WORDS / M_DATA_WORDS;
  localparam int BITS_SUB  = (SUB_BEATS > 1) ? $clog2(SUB_BEATS) : 1;
  localparam int NARROW_W  = WORD_WIDTH * M_DATA_WORDS;
  localparam logic [BITS_SUB-1:0] LAST_IDX = BITS_SUB'(SUB_BEATS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                             state;
  logic [SUB_BEATS-1:0][NARROW_W-1:0] hold_data;
  logic                               hold_last;
  logic [BITS_SUB-1:0]                idx;

  logic full;
  logic at_last;
  logic m_fire;
  logic last_fire;
  logic s_fire;
  logic load;

  // Only the config flag of tuser is meaningful here; the rest is ignored.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign full      = (state == SEND);
  assign at_last   = (idx == LAST_IDX);
  assign m_fire    = full && m_axis_tready;
  assign last_fire = m_fire && at_last;

  // Ready depends only on downstream ready, never on s_axis_tvalid, so the
  // slot can be refilled in the same cycle the final sub-beat leaves.
  assign s_axis_tready = !full || (at_last && m_axis_tready);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign load          = s_fire && !s_axis_tuser[I_IS_CONFIG];

  assign m_axis_tvalid = full;
  assign m_axis_tlast  = full && hold_last && at_last;
  assign m_axis_tdata  = hold_data[idx];
  assign m_axis_tkeep  = '1;

  // Control FSM: occupancy, sub-beat position and frame-last flag.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= EMPTY;
      idx       <= '0;
      hold_last <= 1'b0;
    end else begin
      if (m_fire) begin
        if (at_last || SUB_BEATS == 1) idx <= '0;
        else                           idx <= idx + 1'b1;
      end
      if (load) begin
        state     <= SEND;
        idx       <= '0;
        hold_last <= s_axis_tlast;
      end else if (last_fire) begin
        state <= EMPTY;
      end
    end
  end

  // Wide-beat payload capture on every accepted data beat.
  // NOTE: the payload register has no reset; it is only observed while the
  // reset-cleared state says it is full, so resetting it would buy nothing.
  always_ff @(posedge aclk) begin
    if (load) hold_data <= s_axis_tdata;
  end

endmodule

// File: tb/tb_axis_output_pipe.sv
// Self-checking bench for axis_output_pipe. A scoreboard queue receives the
// expected narrow beats when a wide data beat is accepted; a monitor pops and
// compares on every output handshake and checks stall stability.
module tb_axis_output_pipe;

  localparam int WW     = 8;
  localparam int IN_W   = 16;
  localparam int MW     = 4;
  localparam int SUBS   = IN_W / MW;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               s_axis_tready;
  logic               s_axis_tvalid;
  logic               s_axis_tlast;
  logic [WW*IN_W-1:0] s_axis_tdata;
  logic [3:0]         s_axis_tuser;
  logic               m_axis_tready;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic [WW*MW-1:0]   m_axis_tdata;
  logic [WW*MW/8-1:0] m_axis_tkeep;

  axis_output_pipe dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic             last;
    logic [WW*MW-1:0] data;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Monitor statistics, cleared by the tests that use them.
  int n_fires      = 0;
  int n_last       = 0;
  int first_fire   = 0;
  int last_fire    = 0;
  int n_sready_hi  = 0;
  int accept_cyc   = 0;

  int rdy_mode = 0; // 0: always ready, 1: random 50%, 2: never ready

  always @(posedge aclk) cyc++;

  // Downstream ready generator, updated just after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor and stall-stability checker.
  logic             prev_stall = 1'b0;
  logic [WW*MW-1:0] prev_data;
  logic             prev_last;
  exp_t             exp_beat;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid && s_axis_tready) n_sready_hi++;
      if (m_axis_tvalid && prev_stall) begin
        checks++;
        if (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_hold: data=%h last=%b required data=%h last=%b",
                   m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: data=%h last=%b required no beat",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          exp_beat = sb.pop_front();
          if (m_axis_tdata !== exp_beat.data || m_axis_tlast !== exp_beat.last ||
              m_axis_tkeep !== 4'hF) begin
            failures++;
            $display("FAIL out_beat: data=%h last=%b keep=%h required data=%h last=%b keep=f",
                     m_axis_tdata, m_axis_tlast, m_axis_tkeep, exp_beat.data, exp_beat.last);
          end
        end
        if (n_fires == 0) first_fire = cyc;
        last_fire = cyc;
        n_fires++;
        if (m_axis_tlast) n_last++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  function automatic logic [WW*IN_W-1:0] ramp(input logic [7:0] base);
    logic [WW*IN_W-1:0] d;
    for (int k = 0; k < IN_W; k++) d[k*WW +: WW] = base + 8'(k);
    return d;
  endfunction

  // Expected narrow beats: words 4j..4j+3 with the lowest word in the low byte.
  task automatic push_expected(input logic [WW*IN_W-1:0] d, input logic last);
    exp_t e;
    for (int j = 0; j < SUBS; j++) begin
      for (int w = 0; w < MW; w++) e.data[w*WW +: WW] = d[(j*MW + w)*WW +: WW];
      e.last = last && (j == SUBS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic clear_stats();
    n_fires     = 0;
    n_last      = 0;
    first_fire  = 0;
    last_fire   = 0;
    n_sready_hi = 0;
  endtask

  // Present one wide beat until it is accepted; returns just after that edge.
  task automatic drive_beat(input logic [WW*IN_W-1:0] d, input logic last, input logic cfg);
    bit done = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = {3'b101, cfg};
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        if (!cfg) push_expected(d, last);
        accept_cyc = cyc;
        done = 1;
      end
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 4'h0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: s_axis_tready=%b required 1 within 500 cycles", s_axis_tready);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !m_axis_tvalid) done = 1;
    end
    @(posedge aclk);
    #1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d tvalid=%b required 0 and 0", sb.size(), m_axis_tvalid);
    end
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: tvalid=%b tlast=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: s_tready=%b tvalid=%b required 1 0", s_axis_tready, m_axis_tvalid);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_single();
    rdy_mode = 0;
    clear_stats();
    drive_beat(ramp(8'h00), 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (n_fires != 4 || n_last != 1) begin
      failures++;
      $display("FAIL single_count: beats=%0d lasts=%0d required 4 1", n_fires, n_last);
    end
    checks++;
    if (first_fire != accept_cyc + 1) begin
      failures++;
      $display("FAIL single_latency: first=%0d required %0d", first_fire, accept_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    clear_stats();
    for (int k = 0; k < 8; k++) drive_beat(ramp(8'(k * 16)), k == 7, 1'b0);
    wait_drain();
    checks++;
    if (n_fires != 32 || last_fire - first_fire != 31) begin
      failures++;
      $display("FAIL stream_gapless: beats=%0d span=%0d required 32 31", n_fires, last_fire - first_fire);
    end
    checks++;
    if (n_last != 1) begin
      failures++;
      $display("FAIL stream_tlast: lasts=%0d required 1", n_last);
    end
    checks++;
    if (n_sready_hi != 8) begin
      failures++;
      $display("FAIL stream_sready: high_cycles=%0d required 8", n_sready_hi);
    end
  endtask

  task automatic test_backpressure();
    logic [WW*IN_W-1:0] d;
    rdy_mode = 1;
    clear_stats();
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < IN_W / 4; w++) d[w*32 +: 32] = $urandom;
      drive_beat(d, k == 5, 1'b0);
    end
    wait_drain();
    rdy_mode = 0;
    checks++;
    if (n_fires != 24 || n_last != 1) begin
      failures++;
      $display("FAIL bp_count: beats=%0d lasts=%0d required 24 1", n_fires, n_last);
    end
  endtask

  task automatic test_config_drop();
    rdy_mode = 0;
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      wait_drain();
      checks++;
      if (s_axis_tready !== 1'b1) begin
        failures++;
        $display("FAIL cfg_ready: s_tready=%b required 1", s_axis_tready);
      end
      drive_beat({IN_W{8'hFF}}, 1'b0, 1'b1);
      @(negedge aclk);
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL cfg_no_output: tvalid=%b required 0", m_axis_tvalid);
      end
      @(posedge aclk);
      #1;
      drive_beat(ramp(8'(8'h40 + k * 16)), k == 3, 1'b0);
    end
    wait_drain();
    checks++;
    if (n_fires != 16 || n_last != 1) begin
      failures++;
      $display("FAIL cfg_count: beats=%0d lasts=%0d required 16 1", n_fires, n_last);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit idle_ok = 1;
    rdy_mode = 0;
    clear_stats();
    drive_beat(ramp(8'hA0), 1'b1, 1'b0);
    @(posedge aclk);
    @(posedge aclk);
    #2;
    checks++;
    if (n_fires != 2 || m_axis_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: beats=%0d tvalid=%b required 2 1", n_fires, m_axis_tvalid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: tvalid=%b tlast=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    sb.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid !== 1'b0) idle_ok = 0;
    end
    checks++;
    if (!idle_ok) begin
      failures++;
      $display("FAIL mid_idle: tvalid seen high after release, required 0");
    end
    @(posedge aclk);
    #1;
    drive_beat(ramp(8'h10), 1'b1, 1'b0);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h13121110) begin
      failures++;
      $display("FAIL mid_first_beat: tvalid=%b data=%h required 1 13121110", m_axis_tvalid, m_axis_tdata);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    bit ok = 1;
    rdy_mode = 2;
    @(posedge aclk);
    #2;
    drive_beat(ramp(8'h20), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tdata !== 32'h23222120) begin
        failures++;
        ok = 0;
        $display("FAIL stall_idx0: tvalid=%b s_tready=%b data=%h required 1 0 23222120",
                 m_axis_tvalid, s_axis_tready, m_axis_tdata);
      end
      if (!ok) break;
    end
    rdy_mode = 0;
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_config_drop();
    test_reset_mid_frame();
    test_stall();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
